// File: rtl/mc_path_ctrl.sv
// Monte-Carlo path sequencer: seeds the RNG, steps the path core through
// N_STEPS+1 steps per path and accumulates a saturating 64-bit payoff sum.
module mc_path_ctrl #(
  parameter int unsigned N_STEPS = 10,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_paths,
  input  logic [31:0]      seed_i,
  input  logic [63:0]      payoff_i,
  output logic [7:0]       step,
  output logic             loadseed_o,
  output logic [31:0]      seed_o,
  output logic             busy,
  output logic             done,
  output logic [63:0]      sum_o,
  output logic [CNT_W-1:0] paths_done,
  output logic             overflow
);

  localparam int unsigned STEP_W = 8;
  localparam int unsigned SEED_W = 32;
  localparam int unsigned SUM_W  = 64;

  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEED_W-1:0]  seed_q, seed_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic               load_q, load_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [SUM_W:0]     sum_add;
  logic [CNT_W-1:0]   cnt_inc;

  assign sum_add = (SUM_W+1)'(sum_q) + (SUM_W+1)'(payoff_i);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    step_d  = '0;
    n_d     = n_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    load_d  = 1'b0;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sum_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (n_paths != '0) begin
              n_d     = n_paths;
              seed_d  = seed_i;
              load_d  = 1'b1;
              state_d = SEED;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
        SEED: begin
          state_d = RUN;
        end
        RUN: begin
          if (step_q == STEP_W'(N_STEPS)) begin
            // Final step of a path: fold payoff in, saturating on carry out
            if (sum_add[SUM_W]) begin
              sum_d = '1;
              ovf_d = 1'b1;
            end else begin
              sum_d = sum_add[SUM_W-1:0];
            end
            cnt_d = cnt_inc;
            if (cnt_inc == n_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == SEED) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      seed_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      load_q  <= load_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign step       = step_q;
  assign loadseed_o = load_q;
  assign seed_o     = seed_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sum_o      = sum_q;
  assign paths_done = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mc_path_ctrl.sv
// Directed bench for mc_path_ctrl: table of complete runs plus hand-written
// abort, reset-mid-run and held-start sequences.
module tb_mc_path_ctrl;

  localparam int unsigned N_STEPS = 10;
  localparam int unsigned CNT_W   = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_paths;
  logic [31:0]      seed_i;
  logic [63:0]      payoff_i;
  logic [7:0]       step;
  logic             loadseed_o;
  logic [31:0]      seed_o;
  logic             busy;
  logic             done;
  logic [63:0]      sum_o;
  logic [CNT_W-1:0] paths_done;
  logic             overflow;

  mc_path_ctrl #(.N_STEPS(N_STEPS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .n_paths    (n_paths),
    .seed_i     (seed_i),
    .payoff_i   (payoff_i),
    .step       (step),
    .loadseed_o (loadseed_o),
    .seed_o     (seed_o),
    .busy       (busy),
    .done       (done),
    .sum_o      (sum_o),
    .paths_done (paths_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  int          r_done_edge;
  int          r_loads;
  int          r_step_err;
  logic        r_busy_seen;
  logic [31:0] r_load_seed;

  typedef struct {
    logic [CNT_W-1:0] np;
    logic [63:0]      pay;
    logic [31:0]      sd;
    logic [63:0]      exp_sum;
    logic [CNT_W-1:0] exp_paths;
    logic             exp_ovf;
    int               exp_done;
    int               exp_loads;
    logic [31:0]      exp_seed;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; applies start and watches edges until done (bounded)
  task automatic do_run(input logic [CNT_W-1:0] np, input logic [63:0] pay,
                        input logic [31:0] sd, input bit hold_start);
    int exp_step;
    n_paths     = np;
    payoff_i    = pay;
    seed_i      = sd;
    start       = 1'b1;
    r_done_edge = -1;
    r_loads     = 0;
    r_step_err  = 0;
    r_busy_seen = 1'b0;
    r_load_seed = '0;
    for (int e = 1; e <= 500 && r_done_edge < 0; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (loadseed_o) begin
        r_loads++;
        r_load_seed = seed_o;
      end
      if (busy) r_busy_seen = 1'b1;
      exp_step = 0;
      if (np != '0 && e >= 2) exp_step = (e - 2) % (N_STEPS + 1);
      if (done) begin
        exp_step    = 0;
        r_done_edge = e;
      end
      if (int'(step) != exp_step) r_step_err++;
    end
    if (!hold_start) start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{np: 16'd3, pay: 64'd5, sd: 32'd7, exp_sum: 64'd15, exp_paths: 16'd3,
                exp_ovf: 1'b0, exp_done: 35, exp_loads: 1, exp_seed: 32'd7};
    vecs[1] = '{np: 16'd0, pay: 64'd9, sd: 32'h55, exp_sum: 64'd0, exp_paths: 16'd0,
                exp_ovf: 1'b0, exp_done: 1, exp_loads: 0, exp_seed: 32'd7};
    vecs[2] = '{np: 16'd2, pay: 64'hFFFF_FFFF_FFFF_FFF0, sd: 32'hDEAD_BEEF,
                exp_sum: 64'hFFFF_FFFF_FFFF_FFFF, exp_paths: 16'd2,
                exp_ovf: 1'b1, exp_done: 24, exp_loads: 1, exp_seed: 32'hDEAD_BEEF};
    vecs[3] = '{np: 16'd1, pay: 64'd100, sd: 32'hABCD, exp_sum: 64'd100, exp_paths: 16'd1,
                exp_ovf: 1'b0, exp_done: 13, exp_loads: 1, exp_seed: 32'hABCD};

    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    n_paths  = '0;
    seed_i   = '0;
    payoff_i = '0;

    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum",  sum_o, 64'd0);
    check("rst_step", 64'(step), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven complete runs
    for (int i = 0; i < 4; i++) begin
      do_run(vecs[i].np, vecs[i].pay, vecs[i].sd, 1'b0);
      check($sformatf("v%0d_done_edge", i), 64'(r_done_edge), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_sum", i), sum_o, vecs[i].exp_sum);
      check($sformatf("v%0d_paths", i), 64'(paths_done), 64'(vecs[i].exp_paths));
      check($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
      check($sformatf("v%0d_loads", i), 64'(r_loads), 64'(vecs[i].exp_loads));
      check($sformatf("v%0d_seed", i), 64'(seed_o), 64'(vecs[i].exp_seed));
      check($sformatf("v%0d_step_seq", i), 64'(r_step_err), 64'd0);
      check($sformatf("v%0d_busy_seen", i), 64'(r_busy_seen), 64'(vecs[i].np != '0));
      if (vecs[i].exp_loads == 1)
        check($sformatf("v%0d_load_seed", i), 64'(r_load_seed), 64'(vecs[i].sd));
      tick();
      check($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
      check($sformatf("v%0d_idle_done", i), 64'(done), 64'd0);
    end

    // Abort during step 4 of the second path
    n_paths  = 16'd3;
    payoff_i = 64'd5;
    seed_i   = 32'd11;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && !(step == 8'd4 && paths_done == 16'd1); k++) tick();
    check("ab_reached", 64'(step == 8'd4 && paths_done == 16'd1), 64'd1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    check("ab_busy",  64'(busy), 64'd0);
    check("ab_step",  64'(step), 64'd0);
    check("ab_done",  64'(done), 64'd0);
    check("ab_load",  64'(loadseed_o), 64'd0);
    check("ab_sum",   sum_o, 64'd5);
    check("ab_paths", 64'(paths_done), 64'd1);
    tick();
    check("ab_prio_busy", 64'(busy), 64'd0);
    check("ab_prio_load", 64'(loadseed_o), 64'd0);
    abort = 1'b0;
    start = 1'b0;
    begin
      int pulses = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (done || busy) pulses++;
      end
      check("ab_quiet", 64'(pulses), 64'd0);
    end
    check("ab_hold_sum", sum_o, 64'd5);

    // Reset mid-run after one path has accumulated
    n_paths  = 16'd2;
    payoff_i = 64'd9;
    seed_i   = 32'h1234;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    check("rm_pre_paths", 64'(paths_done), 64'd1);
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("rm_step",  64'(step), 64'd0);
    check("rm_seed",  64'(seed_o), 64'd0);
    check("rm_busy",  64'(busy), 64'd0);
    check("rm_sum",   sum_o, 64'd0);
    check("rm_paths", 64'(paths_done), 64'd0);
    check("rm_flags", {61'd0, loadseed_o, done, overflow}, 64'd0);
    tick();
    tick();
    check("rm_nostart", 64'(busy | loadseed_o), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rm_rel_idle", 64'(busy), 64'd0);
    do_run(16'd2, 64'd7, 32'd1, 1'b0);
    check("rm_run_done", 64'(r_done_edge), 64'd24);
    check("rm_run_sum",  sum_o, 64'd14);
    tick();

    // Start held high through a run; restart only from IDLE
    do_run(16'd1, 64'd3, 32'd99, 1'b1);
    check("hs_done_edge", 64'(r_done_edge), 64'd13);
    check("hs_step_seq",  64'(r_step_err), 64'd0);
    check("hs_loads",     64'(r_loads), 64'd1);
    tick();
    check("hs_idle", {62'd0, busy, loadseed_o}, 64'd0);
    tick();
    check("hs_restart", {62'd0, busy, loadseed_o}, 64'd3);
    check("hs_cleared", sum_o, 64'd0);
    abort = 1'b1;
    start = 1'b0;
    tick();
    abort = 1'b0;
    check("hs_abort_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mc_path_ctrl.md
MC_PATH_CTRL -- requirements
Module: mc_path_ctrl

Interface
REQ-001 SHALL have parameter N_STEPS, default 10, meaning the final step index of one path; each path spans steps 0..N_STEPS.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the path counters.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel, effective in any state.
REQ-007 SHALL have port n_paths  input  CNT_W  number of paths, latched at start.
REQ-008 SHALL have port seed_i  input  32  RNG seed, latched at start.
REQ-009 SHALL have port payoff_i  input  64  unsigned payoff from the path core, valid when step==N_STEPS.
REQ-010 SHALL have port step  output  8  step index driven to the path core and its RNG.
REQ-011 SHALL have port loadseed_o  output  1  one-cycle RNG seed load strobe.
REQ-012 SHALL have port seed_o  output  32  latched seed presented to the RNG.
REQ-013 SHALL have port busy  output  1  high in SEED and RUN.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port sum_o  output  64  accumulated payoff sum.
REQ-016 SHALL have port paths_done  output  CNT_W  number of paths accumulated.
REQ-017 SHALL have port overflow  output  1  sticky saturation flag.

Function
REQ-018 SHALL implement the states IDLE, SEED, RUN and DONE.
REQ-019 In IDLE with start=1 and n_paths>0, the block SHALL latch n_paths and seed_i, clear sum_o, paths_done and overflow, and go to SEED.
REQ-020 In IDLE with start=1 and n_paths=0, the block SHALL clear sum_o, paths_done and overflow, and go directly to DONE.
REQ-021 SEED SHALL last exactly one cycle with loadseed_o=1 and step=0, then go to RUN with step=0.
REQ-022 In RUN with step<N_STEPS, step SHALL increment by 1 each cycle.
REQ-023 In RUN with step==N_STEPS, on that clock edge the block SHALL add payoff_i to sum_o, increment paths_done, and set step to 0.
REQ-024 After the add in REQ-023, if the new paths_done equals the latched n_paths, the block SHALL go to DONE; otherwise it SHALL remain in RUN.
REQ-025 Each path SHALL take N_STEPS+1 RUN cycles.
REQ-026 done SHALL be asserted exactly when the block enters DONE, and the edge following the done pulse SHALL return the block to IDLE.
REQ-027 The cycle at which done asserts, counted in rising edges after the edge that samples start, SHALL be 2+n_paths*(N_STEPS+1) for n_paths>0, and 1 for n_paths=0.
REQ-028 The accumulator SHALL be unsigned 64-bit; if a carry out occurs, sum_o SHALL saturate to all ones and overflow SHALL be set.
REQ-029 Once set, overflow SHALL remain set until the next accepted start or reset.
REQ-030 start SHALL be ignored outside IDLE, including a start coinciding with the done cycle.
REQ-031 abort=1 in any state SHALL force IDLE on the next edge with step=0, loadseed_o=0 and done=0, holding sum_o, paths_done and overflow.
REQ-032 abort SHALL take priority over start and over a simultaneous accumulation (no add occurs).
REQ-033 In IDLE and DONE, step SHALL be 0 and loadseed_o SHALL be 0.
REQ-034 seed_o SHALL hold the last latched seed at all times.

Reset
REQ-035 Asserting rst_n low SHALL immediately force IDLE with step=0, loadseed_o=0, seed_o=0, busy=0, done=0, sum_o=0, paths_done=0 and overflow=0, including mid-run.
REQ-036 Release of rst_n SHALL take effect on the next clk edge, and no start SHALL be accepted while rst_n is low.

Verification
REQ-037 Basic run: with N_STEPS=10, n_paths=3, payoff_i=5 and seed_i=7, the block SHALL pulse loadseed_o once with seed_o=7, step SHALL cycle 0..10 three times, done SHALL pulse at edge 35 after start, and the result SHALL be sum_o=15 and paths_done=3.
REQ-038 Zero paths: with n_paths=0, done SHALL pulse 1 edge after start, busy SHALL never rise, loadseed_o SHALL stay 0, and sum_o SHALL be 0.
REQ-039 Saturation: with n_paths=2 and payoff_i=0xFFFF_FFFF_FFFF_FFF0, the result SHALL be sum_o=all ones and overflow=1; a following start SHALL clear overflow.
REQ-040 Abort: abort asserted during the second path's step 4 (n_paths=3, payoff_i=5) SHALL give IDLE next edge, done never pulsing, sum_o=5 and paths_done=1.
REQ-041 Reset mid-run: rst_n low during RUN SHALL immediately give all outputs 0, and a start after release SHALL run normally.
REQ-042 Ignored start: start held high throughout a run SHALL leave the run's timing unchanged; a new run SHALL begin only from IDLE, one edge after done.
